// File: rtl/pipeline_hazard_scheduler_pkg.sv
// Shared types and default sizing for the hazard scheduler and its per-stage match logic.
package pipeline_hazard_scheduler_pkg;

    localparam int DEF_FWD_DEPTH = 3;
    localparam int DEF_REG_COUNT = 8;
    localparam int DEF_LOAD_LAT  = 2;

    // Register addresses are held at a fixed maximum width so the entry type is parameter-independent.
    localparam int MAX_RAW = 8;

    typedef struct packed {
        logic               valid;
        logic [MAX_RAW-1:0] rd;
        logic               isLoad;
    } trkEntry_t;

endpackage

// File: rtl/pipeline_hazard_scheduler_match.sv
// One tracker stage: compares its entry against both source operands and reports forwardability.
module hazard_match_stage
    import pipeline_hazard_scheduler_pkg::*;
#(
    parameter int STAGE    = 0,
    parameter int LOAD_LAT = DEF_LOAD_LAT
) (
    input  trkEntry_t          entry,
    input  logic [MAX_RAW-1:0] rsA,
    input  logic [MAX_RAW-1:0] rsB,
    input  logic               rsAUsed,
    input  logic               rsBUsed,
    output logic               matchA,
    output logic               matchB,
    output logic               fwdOk
);

    assign matchA = rsAUsed && entry.valid && (entry.rd == rsA);
    assign matchB = rsBUsed && entry.valid && (entry.rd == rsB);
    // Load data only exists once the load has reached the LOAD_LAT stage.
    assign fwdOk  = !entry.isLoad || (STAGE >= LOAD_LAT);

endmodule

// File: rtl/pipeline_hazard_scheduler.sv
// Tracks in-flight writebacks, picks the youngest forward source per operand and stalls on load-use.
module pipeline_hazard_scheduler
    import pipeline_hazard_scheduler_pkg::*;
#(
    parameter int FWD_DEPTH = DEF_FWD_DEPTH,
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int LOAD_LAT  = DEF_LOAD_LAT,
    localparam int RAW      = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RAW-1:0]       rs_a,
    input  logic [RAW-1:0]       rs_b,
    input  logic                 rs_a_used,
    input  logic                 rs_b_used,
    input  logic [RAW-1:0]       rd,
    input  logic                 rd_we,
    input  logic                 is_load,
    output logic [FWD_DEPTH-1:0] fwd_sel_a,
    output logic [FWD_DEPTH-1:0] fwd_sel_b,
    output logic                 stall,
    output logic [7:0]           stall_cnt
);

    trkEntry_t [FWD_DEPTH-1:0] trk;
    logic [FWD_DEPTH-1:0]      matchA, matchB, fwdOk;
    logic [FWD_DEPTH-1:0]      selA, selB;
    logic                      hitA, hitB, okA, okB;
    logic                      issue;
    trkEntry_t                 newEnt;
    logic [7:0]                stallCnt;

    for (genvar i = 0; i < FWD_DEPTH; i++) begin : g_stage
        hazard_match_stage #(
            .STAGE   (i),
            .LOAD_LAT(LOAD_LAT)
        ) u_match (
            .entry  (trk[i]),
            .rsA    (MAX_RAW'(rs_a)),
            .rsB    (MAX_RAW'(rs_b)),
            .rsAUsed(rs_a_used),
            .rsBUsed(rs_b_used),
            .matchA (matchA[i]),
            .matchB (matchB[i]),
            .fwdOk  (fwdOk[i])
        );
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hitA = 1'b0;
        hitB = 1'b0;
        okA  = 1'b0;
        okB  = 1'b0;
        selA = '0;
        selB = '0;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (matchA[i]) begin
                hitA    = 1'b1;
                okA     = fwdOk[i];
                selA    = '0;
                selA[i] = 1'b1;
            end
            if (matchB[i]) begin
                hitB    = 1'b1;
                okB     = fwdOk[i];
                selB    = '0;
                selB[i] = 1'b1;
            end
        end
    end

    assign stall     = in_valid && ((hitA && !okA) || (hitB && !okB));
    assign in_ready  = clk_en && !stall && !flush;
    assign fwd_sel_a = stall ? '0 : selA;
    assign fwd_sel_b = stall ? '0 : selB;
    assign stall_cnt = stallCnt;

    assign issue = in_valid && in_ready && rd_we;

    always_comb begin
        newEnt = '0;
        if (issue) begin
            newEnt.valid  = 1'b1;
            newEnt.rd     = MAX_RAW'(rd);
            newEnt.isLoad = is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk      <= '0;
            stallCnt <= 8'd0;
        end else if (clk_en) begin
            if (flush) begin
                trk <= '0;
            end else begin
                for (int i = FWD_DEPTH - 1; i > 0; i--) trk[i] <= trk[i-1];
                trk[0] <= newEnt;
            end
            if (stall && stallCnt != 8'hFF) stallCnt <= stallCnt + 8'd1;
        end
    end

endmodule
